regfile_wb_ctrl: RTL and testbench
==================================

# regfile_wb_ctrl

Write-back controller that owns the register file's single write port (we3/a3/wd3). It merges single-cycle ALU results with long-latency load/multiply results and buffers the latter in a small FIFO. It keeps a 32-bit pending-write scoreboard so decode can stall on registers whose long-latency result has not yet been written. It sits between the execute/memory stages and the register file, which captures writes on the falling edge of the same clock.

## Interface
- DEPTH, 2: long-latency FIFO entries (≥1)
- DW, 32: data width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle; always accepted
- alu_rd  in  5  ALU destination register
- alu_data  in  DW  ALU result
- lsu_valid  in  1  long-latency result offered
- lsu_ready  out  1  long-latency result accepted when valid&&ready at posedge
- lsu_rd  in  5  long-latency destination
- lsu_data  in  DW  long-latency result
- iss_valid  in  1  long-latency op issued this cycle
- iss_rd  in  5  its destination
- q_a1, q_a2  in  5  decode source-register queries
- busy1, busy2  out  1  pending long-latency write to q_a1 / q_a2 (combinational)
- we3  out  1  register-file write enable (registered)
- a3  out  5  write address (registered)
- wd3  out  DW  write data (registered)
- pend  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- Write-port arbitration on each posedge, in priority order:
  - alu_valid && alu_rd≠0: drive the ALU result.
  - else FIFO non-empty: pop the head and drive it.
  - else lsu_valid && lsu_ready && lsu_rd≠0: bypass the FIFO and drive the LSU result directly.
  - else we3=0; a3 and wd3 hold their previous values.
- LSU push: an LSU handshake not consumed by the bypass is pushed into the FIFO. Entries with rd=0 are accepted and dropped, never written.
- lsu_ready = (pend < DEPTH), derived from registered occupancy only. A full FIFO refuses a push even when a pop occurs in the same cycle.
- LSU results are written in acceptance order.
- The ALU may starve the FIFO indefinitely. Back-pressure is carried by lsu_ready alone.
- Scoreboard (busy[31:0], bit 0 constant 0):
  - iss_valid && iss_rd≠0 sets busy[iss_rd].
  - A long-latency write (pop or bypass) clears busy[its rd].
  - Set and clear of the same register in the same cycle: set wins.
  - ALU writes never touch busy.
- busy1 = busy[q_a1]; busy2 = busy[q_a2]. Purely combinational from the registered mask.

## Timing
- Reset (asynchronous, immediate): we3=0, a3=0, wd3=0, pend=0, busy=0.
  - lsu_ready=1 during and after reset. A handshake during reset is discarded.
- ALU result sampled at edge N: we3 high for cycle N→N+1. The register file captures it at the falling edge mid-cycle, and combinational reads reflect it in the second half of that cycle.
- LSU latency:
  - 1 cycle via bypass (no ALU, FIFO empty).
  - Otherwise ≥2 cycles, plus one cycle per blocking ALU write and per older entry.
- The busy bit drops at the same edge that asserts we3 for that write.
- we3 is high for exactly one cycle per write. Back-to-back writes on consecutive cycles are allowed.
- Reset mid-operation: FIFO contents and pending busy bits are lost; no write is emitted.

## Structure
- Shared package: DW, address width 5, register count 32, reg-0 constant.
- Sub-module wb_fifo: parameterised DEPTH×(5+DW) synchronous FIFO with async reset, push/pop/count/full/empty. Same-cycle push and pop are legal when non-empty.
- Top level holds the arbitration mux, bypass path, output registers and scoreboard.

## Test plan
- Reset then idle: we3=0, a3=0, wd3=0, lsu_ready=1, busy1=busy2=0 for q_a1=5, q_a2=31.
- ALU write alu_rd=3, data 0xDEADBEEF; ALU write alu_rd=0, data 0x1 on the next cycle → one cycle of we3=1/a3=3/wd3=0xDEADBEEF, then we3=0.
- iss_rd=7, then LSU rd=7 data 0x55 while idle → busy1 (q_a1=7) high until the bypass edge; we3=1/a3=7/wd3=0x55 one cycle after acceptance; busy clears at that same edge.
- ALU valid every cycle for 6 cycles with LSU offering rd=4/0x10, 5/0x20, 6/0x30 → two accepted, lsu_ready=0, third stalls; after the ALU stops, writes 4, 5 occur on consecutive cycles, then 6.
- iss_valid with iss_rd=9 on the same edge that an LSU rd=9 write pops → busy[9] remains 1.
- Assert reset with pend=2 and busy[4]=1 → outputs zero immediately; after release no write of the flushed entries appears and busy1 (q_a1=4)=0.

Source files
------------

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared constants and types for the register-file write-back controller.
package regfile_wb_ctrl_pkg;

    localparam int unsigned DW_DEFAULT = 32;
    localparam int unsigned AW         = 5;
    localparam int unsigned NREG       = 32;
    localparam logic [AW-1:0] REG_ZERO = '0;

    // Which source owns the write port on the coming edge.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_FIFO,
        SRC_BYP
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_ctrl_wb_fifo.sv
// Small synchronous FIFO holding accepted long-latency results {rd, data}.
module wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 37
) (
    input  logic                       clk,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full_o   = (cnt_q == CW'(DEPTH));
        empty_o  = (cnt_q == '0);
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Owns the register-file write port: ALU results first, then buffered or
// bypassed long-latency results, plus a pending-write scoreboard for decode.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = DW_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  logic [AW-1:0]              alu_rd,
    input  logic [DW-1:0]              alu_data,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [AW-1:0]              lsu_rd,
    input  logic [DW-1:0]              lsu_data,
    input  logic                       iss_valid,
    input  logic [AW-1:0]              iss_rd,
    input  logic [AW-1:0]              q_a1,
    input  logic [AW-1:0]              q_a2,
    output logic                       busy1,
    output logic                       busy2,
    output logic                       we3,
    output logic [AW-1:0]              a3,
    output logic [DW-1:0]              wd3,
    output logic [$clog2(DEPTH+1)-1:0] pend
);

    localparam int unsigned EW = AW + DW;

    logic [EW-1:0]   fifo_head;
    logic            fifo_full, fifo_empty;
    logic            push, pop, hs, alu_take;
    wb_src_e         src;

    logic            we3_q, we3_d;
    logic [AW-1:0]   a3_q, a3_d;
    logic [DW-1:0]   wd3_q, wd3_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] set_m, clr_m;

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({lsu_rd, lsu_data}),
        .dout_o  (fifo_head),
        .count_o (pend),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Ready depends only on registered occupancy, so a pop never frees a slot early.
    assign lsu_ready = !fifo_full;

    always_comb begin
        alu_take = alu_valid && (alu_rd != REG_ZERO);
        hs       = lsu_valid && lsu_ready;

        src = SRC_NONE;
        if (alu_take) begin
            src = SRC_ALU;
        end else if (!fifo_empty) begin
            src = SRC_FIFO;
        end else if (hs && (lsu_rd != REG_ZERO)) begin
            src = SRC_BYP;
        end

        pop = (src == SRC_FIFO);
        // rd=0 handshakes are accepted but never stored.
        push = hs && (lsu_rd != REG_ZERO) && (src != SRC_BYP);

        we3_d = 1'b0;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        case (src)
            SRC_ALU: begin
                we3_d = 1'b1;
                a3_d  = alu_rd;
                wd3_d = alu_data;
            end
            SRC_FIFO: begin
                we3_d         = 1'b1;
                {a3_d, wd3_d} = fifo_head;
            end
            SRC_BYP: begin
                we3_d = 1'b1;
                a3_d  = lsu_rd;
                wd3_d = lsu_data;
            end
            default: ;
        endcase

        set_m = '0;
        clr_m = '0;
        if (iss_valid && (iss_rd != REG_ZERO)) begin
            set_m[iss_rd] = 1'b1;
        end
        if ((src == SRC_FIFO) || (src == SRC_BYP)) begin
            clr_m[a3_d] = 1'b1;
        end
        busy_d    = (busy_q & ~clr_m) | set_m;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we3_q  <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
            busy_q <= '0;
        end else begin
            we3_q  <= we3_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
            busy_q <= busy_d;
        end
    end

    assign we3   = we3_q;
    assign a3    = a3_q;
    assign wd3   = wd3_q;
    assign busy1 = busy_q[q_a1];
    assign busy2 = busy_q[q_a2];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with a queue-based reference model.
module tb_regfile_wb_ctrl;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  q_a1, q_a2;
    logic        busy1, busy2;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [1:0]  pend;

    regfile_wb_ctrl #(
        .DEPTH (DEPTH),
        .DW    (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .q_a1      (q_a1),
        .q_a2      (q_a2),
        .busy1     (busy1),
        .busy2     (busy2),
        .we3       (we3),
        .a3        (a3),
        .wd3       (wd3),
        .pend      (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted LSU results wait in a queue; each edge grants
    // one write to ALU, else oldest queued result, else a fresh LSU result.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t        m_q[$];
    ent_t        m_e;
    bit          m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [31:0] m_busy;
    bit          m_acc, m_byp;
    int          m_clr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_we   = 1'b0;
            m_a3   = '0;
            m_wd   = '0;
            m_busy = '0;
        end else begin
            m_acc = lsu_valid && (m_q.size() < DEPTH);
            m_byp = 1'b0;
            m_clr = 0;
            m_we  = 1'b0;
            if (alu_valid && alu_rd != 5'd0) begin
                m_we = 1'b1; m_a3 = alu_rd; m_wd = alu_data;
            end else if (m_q.size() != 0) begin
                m_e  = m_q.pop_front();
                m_we = 1'b1; m_a3 = m_e.rd; m_wd = m_e.d; m_clr = int'(m_e.rd);
            end else if (m_acc && lsu_rd != 5'd0) begin
                m_we = 1'b1; m_a3 = lsu_rd; m_wd = lsu_data; m_clr = int'(lsu_rd);
                m_byp = 1'b1;
            end
            if (m_acc && !m_byp && lsu_rd != 5'd0) m_q.push_back('{lsu_rd, lsu_data});
            if (m_clr != 0) m_busy[m_clr] = 1'b0;
            if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
        end
    end

    always @(posedge clk) begin
        #3;
        check("cmp_we3", we3, m_we);
        check("cmp_a3", a3, m_a3);
        check("cmp_wd3", wd3, m_wd);
        check("cmp_pend", pend, m_q.size());
        check("cmp_ready", lsu_ready, m_q.size() < DEPTH);
        check("cmp_busy1", busy1, m_busy[q_a1]);
        check("cmp_busy2", busy2, m_busy[q_a2]);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    logic [4:0]  lr [8];
    logic [31:0] ld [8];
    int          li;
    bit          acc;

    initial begin
        reset = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
        iss_valid = 0; iss_rd = 0; q_a1 = 5'd5; q_a2 = 5'd31;
        lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'h7;
        for (int i = 0; i < 8; i++) begin lr[i] = 5'd0; ld[i] = '0; end
        lr[0] = 5'd4; ld[0] = 32'h10;
        lr[1] = 5'd5; ld[1] = 32'h20;
        lr[2] = 5'd6; ld[2] = 32'h30;

        cyc(); cyc();
        check("rst_we3", we3, 0);
        check("rst_a3", a3, 0);
        check("rst_wd3", wd3, 0);
        check("rst_ready", lsu_ready, 1);
        check("rst_pend", pend, 0);
        lsu_valid = 1'b0;
        reset = 1'b0;
        cyc();
        check("idle_we3", we3, 0);
        check("idle_pend", pend, 0);
        check("idle_busy1", busy1, 0);
        check("idle_busy2", busy2, 0);

        // ALU write then rd=0 ALU result (ignored)
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
        cyc();
        check("alu_we3", we3, 1);
        check("alu_a3", a3, 3);
        check("alu_wd3", wd3, 32'hDEADBEEF);
        alu_rd = 5'd0; alu_data = 32'h1;
        cyc();
        check("alu0_we3", we3, 0);
        check("alu0_a3_hold", a3, 3);
        check("alu0_wd3_hold", wd3, 32'hDEADBEEF);
        alu_valid = 0;

        // Issue then bypass write clears busy at the write edge
        iss_valid = 1; iss_rd = 5'd7; q_a1 = 5'd7;
        cyc();
        check("iss_busy1", busy1, 1);
        iss_valid = 0; lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h55;
        check("byp_ready", lsu_ready, 1);
        cyc();
        check("byp_we3", we3, 1);
        check("byp_a3", a3, 7);
        check("byp_wd3", wd3, 32'h55);
        check("byp_busy1", busy1, 0);
        check("byp_pend", pend, 0);
        lsu_valid = 0;
        cyc();
        check("byp_once", we3, 0);

        // ALU starves FIFO; back-pressure at DEPTH
        li = 0;
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'h100 + i;
            lsu_valid = 1; lsu_rd = lr[li]; lsu_data = ld[li];
            acc = lsu_ready;
            cyc();
            if (acc && li < 7) li++;
            check("starve_a3", a3, 10 + i);
        end
        check("starve_accepted", li, 2);
        check("starve_pend", pend, 2);
        check("starve_ready", lsu_ready, 0);
        alu_valid = 0;
        cyc();
        check("drain4_we3", we3, 1);
        check("drain4_a3", a3, 4);
        check("drain4_wd3", wd3, 32'h10);
        check("drain4_pend", pend, 1);
        cyc();
        check("drain5_a3", a3, 5);
        check("drain5_wd3", wd3, 32'h20);
        check("drain5_pend", pend, 1);
        lsu_valid = 0;
        cyc();
        check("drain6_a3", a3, 6);
        check("drain6_wd3", wd3, 32'h30);
        check("drain6_pend", pend, 0);
        cyc();
        check("drain_idle", we3, 0);

        // Set and clear of the same register on one edge: set wins
        alu_valid = 1; alu_rd = 5'd1; alu_data = 32'hAA;
        lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 32'h99;
        cyc();
        check("sw_pend", pend, 1);
        alu_valid = 0; lsu_valid = 0; iss_valid = 1; iss_rd = 5'd9; q_a2 = 5'd9;
        cyc();
        check("sw_a3", a3, 9);
        check("sw_wd3", wd3, 32'h99);
        check("sw_busy2", busy2, 1);
        iss_valid = 0;
        cyc();
        check("sw_busy2_hold", busy2, 1);

        // Reset with two buffered entries and a pending busy bit
        iss_valid = 1; iss_rd = 5'd4;
        alu_valid = 1; alu_rd = 5'd2; alu_data = 32'h22;
        lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'hA;
        cyc();
        iss_valid = 0; lsu_rd = 5'd8; lsu_data = 32'hB; q_a1 = 5'd4;
        cyc();
        check("pre_rst_pend", pend, 2);
        check("pre_rst_busy1", busy1, 1);
        alu_valid = 0; lsu_valid = 0; reset = 1;
        #1;
        check("mid_rst_we3", we3, 0);
        check("mid_rst_a3", a3, 0);
        check("mid_rst_wd3", wd3, 0);
        check("mid_rst_pend", pend, 0);
        check("mid_rst_ready", lsu_ready, 1);
        check("mid_rst_busy1", busy1, 0);
        cyc(); cyc();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("post_rst_we3", we3, 0);
            check("post_rst_busy1", busy1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
